// File: rtl/led7seg_hc595_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_hc595_scan_if
// Purpose  : BCD-side inputs and 74HC595 pin outputs of the 4-digit scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface led7seg_hc595_scan_if;
    logic       en;
    logic [3:0] dig_0;
    logic [3:0] dig_1;
    logic [3:0] dig_2;
    logic [3:0] dig_3;
    logic [3:0] dp_en;
    logic       blank_lz;
    logic       ser;
    logic       sclk;
    logic       rclk;
    logic [1:0] scan_idx;
    logic       frame_done;

    modport master (
        output en, dig_0, dig_1, dig_2, dig_3, dp_en, blank_lz,
        input  ser, sclk, rclk, scan_idx, frame_done
    );

    modport slave (
        input  en, dig_0, dig_1, dig_2, dig_3, dp_en, blank_lz,
        output ser, sclk, rclk, scan_idx, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/led7seg_hc595_scan.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_hc595_scan
// Purpose  : 4-digit multiplexed 7-segment driver for two cascaded 74HC595s;
//            shifts {segments, 0000, select} MSB first, latches, holds, advances.
// Revision : 1.0 - initial release
// ============================================================================
module led7seg_hc595_scan #(
    parameter int CLK_DIV        = 2,
    parameter int SCAN_HOLD      = 1000,
    parameter bit COMMON_ANODE   = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input wire                  clk,
    input wire                  rst_n,
    led7seg_hc595_scan_if.slave bus
);
    localparam int c_cnt_max = (SCAN_HOLD > CLK_DIV) ? SCAN_HOLD : CLK_DIV;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(SCAN_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4,
        HOLD     = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [15:0]          word_q, word_d;
    logic [1:0]           scan_idx_q, scan_idx_d;
    logic [15:0]          snap_dig_q, snap_dig_d;
    logic [3:0]           snap_dp_q, snap_dp_d;
    logic                 snap_blz_q, snap_blz_d;
    logic                 ser_q, ser_d;
    logic                 sclk_q, sclk_d;
    logic                 rclk_q, rclk_d;
    logic                 frame_done_q, frame_done_d;

    logic [15:0]          w_digits;
    logic [3:0]           w_dp;
    logic                 w_blz;
    logic [3:0]           w_cur;
    logic                 w_z3, w_z2, w_z1;
    logic                 w_blank;
    logic [7:0]           w_seg_byte;
    logic [3:0]           w_sel;
    logic [15:0]          w_word;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Digit 0 reads the live inputs so its word matches the snapshot taken in the same LOAD.
    always_comb begin
        w_digits = snap_dig_q;
        w_dp     = snap_dp_q;
        w_blz    = snap_blz_q;
        if (scan_idx_q == 2'd0) begin
            w_digits = {bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0};
            w_dp     = bus.dp_en;
            w_blz    = bus.blank_lz;
        end
        w_cur      = w_digits[{scan_idx_q, 2'b00} +: 4];
        w_z3       = (w_digits[15:12] == 4'd0);
        w_z2       = w_z3 && (w_digits[11:8] == 4'd0);
        w_z1       = w_z2 && (w_digits[7:4] == 4'd0);
        w_blank    = w_blz && ({w_z3, w_z2, w_z1, 1'b0} >> scan_idx_q) != 4'd0
                     && (scan_idx_q != 2'd0)
                     && ((scan_idx_q == 2'd3) ? w_z3 : (scan_idx_q == 2'd2) ? w_z2 : w_z1);
        w_seg_byte = {w_dp[scan_idx_q], (w_blank ? 7'h00 : seg7(w_cur))};
        w_sel      = 4'b0001 << scan_idx_q;
        if (COMMON_ANODE) begin
            w_seg_byte = ~w_seg_byte;
        end
        if (SEL_ACTIVE_LOW) begin
            w_sel = ~w_sel;
        end
        w_word = {w_seg_byte, 4'h0, w_sel};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        scan_idx_d = scan_idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_blz_d = snap_blz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en) state_d = LOAD;
            end
            LOAD: begin
                if (scan_idx_q == 2'd0) begin
                    snap_dig_d = {bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0};
                    snap_dp_d  = bus.dp_en;
                    snap_blz_d = bus.blank_lz;
                end
                word_d    = w_word;
                bit_cnt_d = 4'd15;
                cnt_d     = '0;
                state_d   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (cnt_q == c_div_last) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == c_div_last) begin
                    cnt_d = '0;
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        word_d    = {word_q[14:0], 1'b0};
                        state_d   = SHIFT_LO;
                    end else begin
                        state_d = LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            LATCH: begin
                if (cnt_q == c_div_last) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            HOLD: begin
                if (cnt_q == c_hold_last) begin
                    cnt_d      = '0;
                    scan_idx_d = scan_idx_q + 2'd1;
                    state_d    = bus.en ? LOAD : IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they register alongside it.
        ser_d        = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? word_d[15] : 1'b0;
        sclk_d       = (state_d == SHIFT_HI);
        rclk_d       = (state_d == LATCH);
        frame_done_d = (state_d == HOLD) && (cnt_d == c_hold_last) && (scan_idx_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= 4'd0;
            word_q       <= 16'h0000;
            scan_idx_q   <= 2'd0;
            snap_dig_q   <= 16'h0000;
            snap_dp_q    <= 4'h0;
            snap_blz_q   <= 1'b0;
            ser_q        <= 1'b0;
            sclk_q       <= 1'b0;
            rclk_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            scan_idx_q   <= scan_idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_blz_q   <= snap_blz_d;
            ser_q        <= ser_d;
            sclk_q       <= sclk_d;
            rclk_q       <= rclk_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ser        = ser_q;
    assign bus.sclk       = sclk_q;
    assign bus.rclk       = rclk_q;
    assign bus.scan_idx   = scan_idx_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_led7seg_hc595_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_led7seg_hc595_scan
// Purpose  : Directed self-checking bench for led7seg_hc595_scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led7seg_hc595_scan;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0     = 0;
    int   fd_ref = 0;
    int   sr_ref = 0;

    led7seg_hc595_scan_if bus ();
    led7seg_hc595_scan_if bus_ca ();

    led7seg_hc595_scan #(
        .CLK_DIV(1), .SCAN_HOLD(4), .COMMON_ANODE(1'b0), .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    led7seg_hc595_scan #(
        .CLK_DIV(2), .SCAN_HOLD(3), .COMMON_ANODE(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut_ca (
        .clk(clk), .rst_n(rst_n), .bus(bus_ca)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial receiver model: rebuilds each latched word from sclk/ser/rclk.
    logic [15:0] m_sh = '0;
    int          m_nbits = 0, m_sclk_rises = 0, m_viol = 0, m_fd_pulses = 0, m_fd_high = 0;
    logic [15:0] m_words[$];
    int          m_idx[$], m_bits[$], m_rcyc[$], m_fd_cyc[$];
    logic        m_psclk = 1'b0, m_prclk = 1'b0, m_pser = 1'b0, m_pfd = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_nbits <= 0;
            m_psclk <= 1'b0;
            m_prclk <= 1'b0;
            m_pser  <= 1'b0;
            m_pfd   <= 1'b0;
        end else begin
            if ((bus.sclk && m_psclk && (bus.ser !== m_pser)) || (bus.sclk && bus.rclk))
                m_viol <= m_viol + 1;
            if (bus.sclk && !m_psclk) begin
                m_sh         <= {m_sh[14:0], bus.ser};
                m_nbits      <= m_nbits + 1;
                m_sclk_rises <= m_sclk_rises + 1;
            end
            if (bus.rclk && !m_prclk) begin
                m_words.push_back(m_sh);
                m_idx.push_back(int'(bus.scan_idx));
                m_bits.push_back(m_nbits);
                m_rcyc.push_back(cyc);
                m_nbits <= 0;
            end
            if (bus.frame_done) begin
                m_fd_high <= m_fd_high + 1;
                if (!m_pfd) begin
                    m_fd_pulses <= m_fd_pulses + 1;
                    m_fd_cyc.push_back(cyc);
                end
            end
            m_psclk <= bus.sclk;
            m_prclk <= bus.rclk;
            m_pser  <= bus.ser;
            m_pfd   <= bus.frame_done;
        end
    end

    logic [15:0] c_sh = '0;
    int          c_viol = 0;
    logic [15:0] c_words[$];
    int          c_rcyc[$];
    logic        c_psclk = 1'b0, c_prclk = 1'b0, c_pser = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            c_psclk <= 1'b0;
            c_prclk <= 1'b0;
            c_pser  <= 1'b0;
        end else begin
            if ((bus_ca.sclk && c_psclk && (bus_ca.ser !== c_pser)) || (bus_ca.sclk && bus_ca.rclk))
                c_viol <= c_viol + 1;
            if (bus_ca.sclk && !c_psclk) c_sh <= {c_sh[14:0], bus_ca.ser};
            if (bus_ca.rclk && !c_prclk) begin
                c_words.push_back(c_sh);
                c_rcyc.push_back(cyc);
            end
            c_psclk <= bus_ca.sclk;
            c_prclk <= bus_ca.rclk;
            c_pser  <= bus_ca.ser;
        end
    end

    logic [15:0] exp_a [4] = '{16'h6601, 16'h0602, 16'h5B04, 16'h4F08};
    logic [15:0] exp_b1[4] = '{16'h0701, 16'h0002, 16'h8004, 16'h0008};
    logic [15:0] exp_b2[4] = '{16'h0701, 16'h3F02, 16'hBF04, 16'h3F08};
    logic [15:0] exp_ca[4] = '{16'h800E, 16'hFF0D, 16'hC00B, 16'h9007};
    logic [15:0] exp_d [8] = '{16'h0601, 16'h0602, 16'h5B04, 16'h4F08,
                               16'h6D01, 16'h0602, 16'h5B04, 16'h7F08};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while ((m_words.size() < n) && (k < 2000)) begin
            tick(1);
            k++;
        end
        chk("word_wait", 32'(m_words.size() >= n), 32'd1);
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic [3:0] dp, input logic blz);
        bus.dig_3 = d3; bus.dig_2 = d2; bus.dig_1 = d1; bus.dig_0 = d0;
        bus.dp_en = dp; bus.blank_lz = blz;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick(2);
        m_words.delete(); m_idx.delete(); m_bits.delete(); m_rcyc.delete();
        rst_n = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        bus.en = 1'b0;
        set_digits(4'd3, 4'd2, 4'd1, 4'd4, 4'b0000, 1'b0);
        bus_ca.en = 1'b0;
        bus_ca.dig_3 = 4'd9; bus_ca.dig_2 = 4'd0; bus_ca.dig_1 = 4'd12; bus_ca.dig_0 = 4'd8;
        bus_ca.dp_en = 4'b0000; bus_ca.blank_lz = 1'b0;
        tick(3);
        chk("rst_ser", bus.ser, 0);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_rclk", bus.rclk, 0);
        chk("rst_scan_idx", bus.scan_idx, 0);
        chk("rst_frame_done", bus.frame_done, 0);

        // Two full frames on the common-cathode unit, one frame on the inverted unit.
        bus.en = 1'b1;
        bus_ca.en = 1'b1;
        rst_n = 1'b1;
        t0 = cyc;
        wait_words(9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("A_word%0d", i), m_words[i], exp_a[i % 4]);
            chk($sformatf("A_idx%0d", i), m_idx[i], i % 4);
            chk($sformatf("A_bits%0d", i), m_bits[i], 16);
        end
        chk("A_first_rclk", m_rcyc[0] - t0, 34);
        chk("A_digit_period", m_rcyc[1] - m_rcyc[0], 38);
        chk("A_fd_pulses", m_fd_pulses, 2);
        chk("A_fd_high", m_fd_high, 2);
        chk("A_fd_period", m_fd_cyc[1] - m_fd_cyc[0], 152);
        chk("A_fd_pos", m_fd_cyc[0] - m_rcyc[3], 4);
        for (int k = 0; (k < 500) && (c_words.size() < 4); k++) tick(1);
        for (int i = 0; i < 4; i++) chk($sformatf("CA_word%0d", i), c_words[i], exp_ca[i]);
        chk("CA_first_rclk", c_rcyc[0] - t0, 66);
        chk("CA_digit_period", c_rcyc[1] - c_rcyc[0], 70);
        bus_ca.en = 1'b0;

        set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b0100, 1'b1);
        restart();
        wait_words(4);
        for (int i = 0; i < 4; i++) chk($sformatf("B_blank_word%0d", i), m_words[i], exp_b1[i]);

        set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b0100, 1'b0);
        restart();
        wait_words(4);
        for (int i = 0; i < 4; i++) chk($sformatf("B_noblank_word%0d", i), m_words[i], exp_b2[i]);

        // Inputs change mid-frame; the new values appear only from the next frame.
        set_digits(4'd3, 4'd2, 4'd1, 4'd1, 4'b0000, 1'b0);
        restart();
        for (int k = 0; (k < 500) && (bus.scan_idx != 2'd2); k++) tick(1);
        bus.dig_0 = 4'd5;
        bus.dig_3 = 4'd8;
        wait_words(8);
        for (int i = 0; i < 8; i++) chk($sformatf("D_word%0d", i), m_words[i], exp_d[i]);

        set_digits(4'd3, 4'd2, 4'd1, 4'd4, 4'b0000, 1'b0);
        for (int k = 0; (k < 500) && !((bus.scan_idx == 2'd2) && (m_nbits == 6)); k++) tick(1);
        chk("E_reached_bit9", bus.scan_idx, 2);
        fd_ref = m_fd_pulses;
        rst_n = 1'b0;
        tick(1);
        chk("E_rst_ser", bus.ser, 0);
        chk("E_rst_sclk", bus.sclk, 0);
        chk("E_rst_rclk", bus.rclk, 0);
        chk("E_rst_scan_idx", bus.scan_idx, 0);
        chk("E_rst_frame_done", bus.frame_done, 0);
        tick(1);
        m_words.delete(); m_idx.delete(); m_bits.delete(); m_rcyc.delete();
        rst_n = 1'b1;
        t0 = cyc;
        wait_words(1);
        chk("E_word0", m_words[0], 16'h6601);
        chk("E_idx0", m_idx[0], 0);
        chk("E_first_rclk", m_rcyc[0] - t0, 34);
        chk("E_no_frame_done", m_fd_pulses, fd_ref);

        // en drops during digit 1's shift: the word finishes, then the scanner idles.
        for (int k = 0; (k < 500) && (m_nbits != 5); k++) tick(1);
        bus.en = 1'b0;
        wait_words(2);
        chk("F_word1", m_words[1], 16'h0602);
        chk("F_bits1", m_bits[1], 16);
        sr_ref = m_sclk_rises;
        tick(40);
        chk("F_no_more_sclk", m_sclk_rises, sr_ref);
        chk("F_no_more_words", m_words.size(), 2);
        chk("F_idle_scan_idx", bus.scan_idx, 2);
        chk("F_idle_sclk", bus.sclk, 0);
        chk("F_idle_rclk", bus.rclk, 0);
        chk("F_idle_ser", bus.ser, 0);
        bus.en = 1'b1;
        wait_words(3);
        chk("F_resume_word", m_words[2], 16'h5B04);
        chk("F_resume_idx", m_idx[2], 2);

        chk("protocol_main", m_viol, 0);
        chk("protocol_ca", c_viol, 0);
        chk("fd_single_cycle", m_fd_high, m_fd_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
